// File: rtl/divider_unit_pkg.sv
// rtl/divider_unit_pkg.sv - shared constants for the restoring divider
package divider_unit_pkg;

    localparam int WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [WIDTH-1:0] ZDIV_QUOTIENT = 4'hF;

endpackage

// File: rtl/arithmetic_unit.sv
// rtl/arithmetic_unit.sv - adder with selectable B operand (0, ~B, B, all ones) and carry-in
module arithmetic_unit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         s1_i,
    input  logic         s0_i,
    input  logic         c_in_i,
    output logic [W-1:0] f_o,
    output logic         c_out_o
);

    logic [W-1:0] y;
    logic [W:0]   sum;

    always_comb begin
        y = '0;
        case ({s1_i, s0_i})
            2'b00:   y = '0;
            2'b01:   y = ~b_i;
            2'b10:   y = b_i;
            default: y = '1;
        endcase
    end

    assign sum     = {1'b0, a_i} + {1'b0, y} + {{W{1'b0}}, c_in_i};
    assign f_o     = sum[W-1:0];
    assign c_out_o = sum[W];

endmodule

// File: rtl/divider_unit.sv
// rtl/divider_unit.sv - 4-bit unsigned restoring divider, one quotient bit per cycle MSB-first
module divider_unit
    import divider_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    logic [1:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] qsr_q, qsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] trial;
    logic             carry;
    logic             accept;

    assign shifted = {r_q[WIDTH-2:0], dvd_q[cnt_q]};

    arithmetic_unit #(.W(WIDTH)) u_sub (
        .a_i     (shifted),
        .b_i     (dvs_q),
        .s1_i    (1'b0),
        .s0_i    (1'b1),
        .c_in_i  (1'b1),
        .f_o     (trial),
        .c_out_o (carry)
    );

    // A set R[3] means the shifted value is >= 16, so it beats any divisor even though the 4-bit adder wrapped.
    assign accept = r_q[WIDTH-1] | carry;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        r_d     = r_q;
        qsr_d   = qsr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        r_d     = '0;
                        qsr_d   = '0;
                        cnt_d   = 2'd3;
                        dbz_d   = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        quo_d   = ZDIV_QUOTIENT;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                r_d   = accept ? trial : shifted;
                qsr_d = {qsr_q[WIDTH-2:0], accept};
                if (cnt_q == 2'd0) begin
                    quo_d   = {qsr_q[WIDTH-2:0], accept};
                    rem_d   = accept ? trial : shifted;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            qsr_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            r_q     <= r_d;
            qsr_q   <= qsr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_divider_unit.sv
// tb/tb_divider_unit.sv - scoreboard bench for divider_unit against an arithmetic reference model
module tb_divider_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    divider_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        int         cyc;
        int         a;
        int         b;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   n_ops  = 0;
    int   n_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must pair with a pending expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("quotient_%0d_%0d", e.a, e.b), quotient, e.q);
                check($sformatf("remainder_%0d_%0d", e.a, e.b), remainder, e.r);
                check($sformatf("dbz_%0d_%0d", e.a, e.b), div_by_zero, e.z);
                check($sformatf("latency_%0d_%0d", e.a, e.b), cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    // Issue one operation; returns with the accept edge just passed (cyc == accept edge index)
    task automatic do_op(input int a, input int b, input bit hold, input bit expect_done);
        exp_t e;
        wait_idle();
        dividend = 4'(a);
        divisor  = 4'(b);
        start    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        if (expect_done) begin
            e.a   = a;
            e.b   = b;
            e.q   = (b == 0) ? 4'hF : 4'(a / b);
            e.r   = (b == 0) ? 4'(a) : 4'(a % b);
            e.z   = (b == 0);
            e.cyc = (b == 0) ? cyc : cyc + 4;
            exp_q.push_back(e);
            n_ops++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        wait_idle();
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(13, 3, 0, 1);
        do_op(15, 1, 0, 1);
        do_op(15, 15, 0, 1);
        do_op(5, 7, 0, 1);
        do_op(9, 0, 0, 1);
        do_op(8, 2, 0, 1);
        drain();

        // Start while busy must be ignored
        do_op(14, 3, 0, 1);
        @(posedge clk);
        #1;
        check("busy_during_run", busy, 1);
        dividend = 4'd6;
        divisor  = 4'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // Reset in the second RUN cycle aborts with no done
        do_op(12, 5, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dbz", div_by_zero, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        do_op(12, 5, 0, 1);
        drain();

        // Exhaustive sweep with start held high back-to-back
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(a, b, 1, 1);
            end
        end
        drain();
        start = 1'b0;

        // A few random operations with random gaps
        for (int i = 0; i < 40; i++) begin
            do_op(int'($urandom_range(15)), int'($urandom_range(15)), 0, 1);
            repeat ($urandom_range(6)) @(posedge clk);
            #1;
        end
        drain();
        repeat (4) @(posedge clk);
        #1;
        check("done_count", n_done, n_ops);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 One clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  4  unsigned dividend; captured on the accepted start.
REQ-006 divisor  input  4  unsigned divisor; captured on the accepted start.
REQ-007 quotient  output  4  registered quotient; valid from the done pulse until the next accepted start.
REQ-008 remainder  output  4  registered remainder; valid from the done pulse until the next accepted start.
REQ-009 busy  output  1  high while in RUN or DONE.
REQ-010 done  output  1  one-cycle pulse marking result valid.
REQ-011 div_by_zero  output  1  registered flag; high with done when divisor was 0; held until the next accepted start.

Function
REQ-012 FSM states: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 and divisor!=0: capture operands, clear partial remainder R[3:0] and quotient shift register, set step counter to 3, go to RUN.
REQ-014 IDLE with start=1 and divisor==0: go to DONE next cycle; quotient=4'hF, remainder=dividend, div_by_zero=1.
REQ-015 RUN: one restoring step per cycle, MSB-first, for exactly 4 cycles (counter 3 down to 0).
REQ-016 Each step: trial = {R[2:0], next dividend bit} minus divisor, computed 4-bit via add of inverted divisor with carry-in 1.
REQ-017 Step accepts the subtraction if R[3]==1 or the adder carry-out==1 (no borrow); then R<=trial and quotient bit=1; otherwise R<={R[2:0], bit} and quotient bit=0.
REQ-018 The 4-bit trial wraps modulo 16; the result is exact because the accepted true value is always less than divisor (at most 15).
REQ-019 After the step with counter 0: go to DONE.
REQ-020 DONE lasts one cycle: done=1, quotient/remainder/div_by_zero update at entry, then return to IDLE.
REQ-021 Latency: the accepted start edge is followed by done high at that edge+5 (nonzero divisor) or edge+1 (zero divisor).
REQ-022 start while busy is ignored; operand changes while busy have no effect.
REQ-023 start held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
REQ-024 Results satisfy dividend == quotient*divisor + remainder with remainder < divisor, for all 240 nonzero-divisor pairs.

Reset
REQ-025 rst_n low, at any time including mid-RUN, forces IDLE immediately.
REQ-026 While rst_n is low, and at deassertion: quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, counter=0, internal operand registers=0.
REQ-027 An interrupted operation produces no done pulse; the first start after reset release is accepted normally.

Structure
REQ-028 Shared package holds the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10), WIDTH=4, and the zero-divide quotient constant 4'hF.
REQ-029 The subtractor is one instance of the team's existing arithmetic_unit, with S1=0, S0=1 (B inverted) and C_in=1; no other sub-module.

Verification
REQ-030 13/3 -> done at start edge+5; quotient=4, remainder=1, div_by_zero=0.
REQ-031 15/1 -> quotient=15, remainder=0; 15/15 -> quotient=1, remainder=0; 5/7 -> quotient=0, remainder=5.
REQ-032 9/0 -> done at start edge+1; quotient=4'hF, remainder=9, div_by_zero=1; the next 8/2 clears the flag -> quotient=4, remainder=0.
REQ-033 Start 14/3; pulse start with 6/2 two cycles later -> second start ignored; result quotient=4, remainder=2.
REQ-034 Start 12/5; assert rst_n low in the 2nd RUN cycle -> all outputs 0, no done; after release, 12/5 -> quotient=2, remainder=2.
REQ-035 Exhaustive sweep of all 256 operand pairs against a reference model, with start held high back-to-back -> every result matches and exactly one done per operation.
